// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, turns MEM exceptions into flush + redirect,
// and drains a stale AXI fetch. Optional perf counters via `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stallreq_if,
  input  logic              i_stallreq_id,
  input  logic              i_stallreq_ex,
  input  logic              i_stallreq_mem,
  input  logic              i_excp_valid,
  input  logic [ADDR_W-1:0] i_excp_target,
  input  logic              i_if_busy,
  output logic [5:0]        o_stall,
  output logic              o_flush,
  output logic [ADDR_W-1:0] o_new_pc,
  output logic              o_if_discard,
  output logic              o_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  o_perf_stall_cycles,
  output logic [CNT_W-1:0]  o_perf_flush_count
`endif
);

  typedef enum logic {S_RUN = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_new_pc;
  logic [5:0]        w_req_stall;

  // Highest-priority request wins; each level also freezes every earlier stage.
  always_comb begin
    if (i_stallreq_mem)     w_req_stall = 6'b011111;
    else if (i_stallreq_ex) w_req_stall = 6'b001111;
    else if (i_stallreq_id) w_req_stall = 6'b000111;
    else if (i_stallreq_if) w_req_stall = 6'b000011;
    else                    w_req_stall = 6'b000000;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN:   if (i_excp_valid && i_if_busy) w_next = S_DRAIN;
      S_DRAIN: if (!i_if_busy) w_next = S_RUN;
      default: w_next = S_RUN;
    endcase
  end

  // During rst every output is forced to its reset value, whatever the inputs do.
  always_comb begin
    o_stall      = 6'b000000;
    o_flush      = 1'b0;
    o_if_discard = 1'b0;
    o_busy       = 1'b0;
    if (!rst) begin
      case (r_state)
        S_RUN: begin
          o_flush = i_excp_valid;
          o_stall = i_excp_valid ? 6'b000000 : w_req_stall;
        end
        S_DRAIN: begin
          o_flush      = i_excp_valid;
          o_stall      = 6'b000001;
          o_if_discard = 1'b1;
          o_busy       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_new_pc = rst     ? '0 :
                    o_flush ? i_excp_target : r_new_pc;

  // Holds the most recent redirect; a flush in DRAIN overwrites it.
  always_ff @(posedge clk) begin
    if (rst)          r_new_pc <= '0;
    else if (o_flush) r_new_pc <= i_excp_target;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_perf_stall;
  logic [CNT_W-1:0] r_perf_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (o_stall[0] && !(&r_perf_stall)) r_perf_stall <= r_perf_stall + 1'b1;
      if (o_flush && !(&r_perf_flush))    r_perf_flush <= r_perf_flush + 1'b1;
    end
  end

  assign o_perf_stall_cycles = r_perf_stall;
  assign o_perf_flush_count  = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vectors push expected outputs into a queue, and a
// negedge monitor pops and compares each cycle. Perf counters checked with PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;
  localparam int AW = 32;
  localparam int CW = 3;
  localparam int EW = 6 + 1 + AW + 1 + 1;

  logic          clk;
  logic          rst;
  logic          stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic          excp_valid;
  logic [AW-1:0] excp_target;
  logic          if_busy;
  logic [5:0]    stall;
  logic          flush;
  logic [AW-1:0] new_pc;
  logic          if_discard;
  logic          busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [CW-1:0] perf_stall_cycles;
  logic [CW-1:0] perf_flush_count;
  logic [CW-1:0] m_stall_cnt;
  logic [CW-1:0] m_flush_cnt;
`endif

  logic [EW-1:0] exp_q[$];
  int            n_checks;
  int            n_fail;

  pipe_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_stallreq_if  (stallreq_if),
    .i_stallreq_id  (stallreq_id),
    .i_stallreq_ex  (stallreq_ex),
    .i_stallreq_mem (stallreq_mem),
    .i_excp_valid   (excp_valid),
    .i_excp_target  (excp_target),
    .i_if_busy      (if_busy),
    .o_stall        (stall),
    .o_flush        (flush),
    .o_new_pc       (new_pc),
    .o_if_discard   (if_discard),
    .o_busy         (busy)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .o_perf_stall_cycles (perf_stall_cycles),
    .o_perf_flush_count  (perf_flush_count)
`endif
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: one call = one clock cycle of inputs plus the outputs expected in that cycle.
  // reqs = {mem, ex, id, if}
  task automatic step(input logic r, input logic [3:0] reqs, input logic ev,
                      input logic [AW-1:0] tgt, input logic ib,
                      input logic [5:0] e_stall, input logic e_flush,
                      input logic [AW-1:0] e_pc, input logic e_disc, input logic e_busy);
    @(posedge clk);
    #1;
    rst          = r;
    stallreq_mem = reqs[3];
    stallreq_ex  = reqs[2];
    stallreq_id  = reqs[1];
    stallreq_if  = reqs[0];
    excp_valid   = ev;
    excp_target  = tgt;
    if_busy      = ib;
    exp_q.push_back({e_stall, e_flush, e_pc, e_disc, e_busy});
`ifdef PIPE_CTRL_PERF_EN
    if (r) begin
      m_stall_cnt = '0;
      m_flush_cnt = '0;
    end else begin
      if (e_stall[0] && !(&m_stall_cnt)) m_stall_cnt = m_stall_cnt + 1'b1;
      if (e_flush && !(&m_flush_cnt))    m_flush_cnt = m_flush_cnt + 1'b1;
    end
`endif
  endtask

  // Scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {stall, flush, new_pc, if_discard, busy};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs #%0d: got stall=%b flush=%b new_pc=%h discard=%b busy=%b, want stall=%b flush=%b new_pc=%h discard=%b busy=%b",
                   n_checks, a[EW-1 -: 6], a[EW-7], a[AW+1:2], a[1], a[0],
                   e[EW-1 -: 6], e[EW-7], e[AW+1:2], e[1], e[0]);
        end
      end
    end
  end

  localparam logic [AW-1:0] T1 = 32'hBFC00380;
  localparam logic [AW-1:0] T2 = 32'h80000180;
  localparam logic [AW-1:0] T3 = 32'h80001000;
  localparam logic [AW-1:0] TX = 32'h12345678;

  initial begin
    int budget;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    excp_valid = 0; excp_target = '0; if_busy = 0;
`ifdef PIPE_CTRL_PERF_EN
    m_stall_cnt = '0;
    m_flush_cnt = '0;
`endif
    // reset holds every output at zero despite active inputs
    step(1, 4'b1111, 1, TX, 1, 6'b000000, 0, '0, 0, 0);
    step(1, 4'b0010, 1, TX, 0, 6'b000000, 0, '0, 0, 0);
    step(0, 4'b0000, 0, '0, 0, 6'b000000, 0, '0, 0, 0);
    // stall priority
    step(0, 4'b0001, 0, '0, 0, 6'b000011, 0, '0, 0, 0);
    step(0, 4'b0010, 0, '0, 0, 6'b000111, 0, '0, 0, 0);
    step(0, 4'b0100, 0, '0, 0, 6'b001111, 0, '0, 0, 0);
    step(0, 4'b1000, 0, '0, 0, 6'b011111, 0, '0, 0, 0);
    step(0, 4'b1111, 0, '0, 0, 6'b011111, 0, '0, 0, 0);
    step(0, 4'b0011, 0, '0, 0, 6'b000111, 0, '0, 0, 0);
    // id+ex for 3 cycles, then drop
    for (int i = 0; i < 3; i++) step(0, 4'b0110, 0, '0, 0, 6'b001111, 0, '0, 0, 0);
    step(0, 4'b0000, 0, '0, 0, 6'b000000, 0, '0, 0, 0);
    // exception with no fetch outstanding: flush beats the mem stall, stay in RUN
    step(0, 4'b1000, 1, T1, 0, 6'b000000, 1, T1, 0, 0);
    step(0, 4'b0000, 0, '0, 0, 6'b000000, 0, T1, 0, 0);
    // exception with fetch outstanding for 4 more cycles
    step(0, 4'b0000, 1, T2, 1, 6'b000000, 1, T2, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 4'b1000, 0, '0, 1, 6'b000001, 0, T2, 1, 1);
    step(0, 4'b1000, 0, '0, 0, 6'b000001, 0, T2, 1, 1);
    step(0, 4'b0000, 0, '0, 0, 6'b000000, 0, T2, 0, 0);
    // second exception while draining overwrites the redirect, state stays DRAIN
    step(0, 4'b0000, 1, T2, 1, 6'b000000, 1, T2, 0, 0);
    step(0, 4'b0000, 0, '0, 1, 6'b000001, 0, T2, 1, 1);
    step(0, 4'b0000, 1, T3, 1, 6'b000001, 1, T3, 1, 1);
    step(0, 4'b0100, 0, '0, 1, 6'b000001, 0, T3, 1, 1);
    step(0, 4'b0000, 0, '0, 0, 6'b000001, 0, T3, 1, 1);
    step(0, 4'b0000, 0, '0, 0, 6'b000000, 0, T3, 0, 0);
    // back-to-back exceptions give back-to-back pulses
    step(0, 4'b0000, 1, T1, 0, 6'b000000, 1, T1, 0, 0);
    step(0, 4'b0000, 1, T2, 0, 6'b000000, 1, T2, 0, 0);
    step(0, 4'b0000, 0, '0, 0, 6'b000000, 0, T2, 0, 0);
    // reset mid-DRAIN
    step(0, 4'b0000, 1, T3, 1, 6'b000000, 1, T3, 0, 0);
    step(0, 4'b0000, 0, '0, 1, 6'b000001, 0, T3, 1, 1);
    step(1, 4'b0000, 0, '0, 1, 6'b000000, 0, '0, 0, 0);
    step(0, 4'b0000, 0, '0, 1, 6'b000000, 0, '0, 0, 0);
    // 5 stall cycles plus 2 exceptions, then more stalls to push a 3-bit counter to saturation
    for (int i = 0; i < 5; i++) step(0, 4'b0001, 0, '0, 0, 6'b000011, 0, '0, 0, 0);
    step(0, 4'b0000, 1, T1, 0, 6'b000000, 1, T1, 0, 0);
    step(0, 4'b0000, 1, T2, 0, 6'b000000, 1, T2, 0, 0);
    step(0, 4'b0000, 0, '0, 0, 6'b000000, 0, T2, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
    @(posedge clk);
    #1;
    n_checks++;
    if (perf_stall_cycles !== m_stall_cnt || m_stall_cnt !== 3'd5) begin
      n_fail++;
      $display("FAIL perf_stall_5: got %0d want 5", perf_stall_cycles);
    end
    n_checks++;
    if (perf_flush_count !== m_flush_cnt || m_flush_cnt !== 3'd2) begin
      n_fail++;
      $display("FAIL perf_flush_2: got %0d want 2", perf_flush_count);
    end
`endif
    for (int i = 0; i < 4; i++) step(0, 4'b1000, 0, '0, 0, 6'b011111, 0, T2, 0, 0);
    step(0, 4'b0000, 0, '0, 0, 6'b000000, 0, T2, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
    @(posedge clk);
    #1;
    n_checks++;
    if (perf_stall_cycles !== 3'd7) begin
      n_fail++;
      $display("FAIL perf_stall_sat: got %0d want 7", perf_stall_cycles);
    end
`endif

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_queue: %0d expected entries left, want 0", exp_q.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
